traffic_sensor_cond: RTL

// - Upstream conditioner for the two-lane traffic-light controller: turns raw, asynchronous,

---
 rtl/traffic_sensor_cond.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: per-lane synchronizer, debounce, presence FSM with gap hold, vehicle count.
// Optional starvation guard is compiled in when TRAFFIC_STARVE_GUARD_EN is defined.
module traffic_sensor_cond #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned HOLD_CYC     = 8,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned MAX_ON       = 64,
    parameter int unsigned FORCE_CYC    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             clr_cnt,
    output logic             ta,
    output logic             tb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             forced_a,
    output logic             forced_b
);
    localparam int unsigned DebW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYC - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {StIdle, StPresent, StExtend, StForce} state_e;

    if (DEBOUNCE_CYC < 1 || HOLD_CYC < 1 || MAX_ON < 1 || FORCE_CYC < 1) begin : g_bad_cfg
        $error("traffic_sensor_cond: cycle parameters must be at least 1");
    end

    logic [1:0]            raw;
    logic [1:0]            t;
    logic [1:0][CNT_W-1:0] cnt;

    assign raw = {raw_b, raw_a};

`ifdef TRAFFIC_STARVE_GUARD_EN
    localparam int unsigned OnW    = (MAX_ON > 1) ? $clog2(MAX_ON) : 1;
    localparam int unsigned ForceW = (FORCE_CYC > 1) ? $clog2(FORCE_CYC) : 1;
    localparam logic [OnW-1:0]    OnLast    = OnW'(MAX_ON - 1);
    localparam logic [ForceW-1:0] ForceLast = ForceW'(FORCE_CYC - 1);

    logic [1:0]          forced;
    logic [1:0]          force_req;
    logic [1:0][OnW-1:0] on_q, on_d;
    logic                both_on;

    assign both_on = t[0] & t[1];
    // Lane A wins a simultaneous limit; lane B then sits at its limit until A is back on.
    assign force_req[0] = both_on && (on_q[0] == OnLast);
    assign force_req[1] = both_on && (on_q[1] == OnLast) && (on_q[0] != OnLast);

    always_comb begin
        on_d = on_q;
        for (int i = 0; i < 2; i++) begin
            if (!t[i]) begin
                on_d[i] = '0;
            end else if (both_on && (on_q[i] != OnLast)) begin
                on_d[i] = on_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_q <= '0;
        end else begin
            on_q <= on_d;
        end
    end
`endif

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic             sync1_q, sync2_q;
        logic             deb_q, deb_d;
        logic [DebW-1:0]  stab_q, stab_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [HoldW-1:0] hold_q, hold_d;
        state_e           state_q, state_d;
        logic             lane_t;
`ifdef TRAFFIC_STARVE_GUARD_EN
        logic [ForceW-1:0] fc_q, fc_d;
        logic              lane_forced;
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                deb_q   <= 1'b0;
                stab_q  <= '0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= raw[i];
                sync2_q <= sync1_q;
                deb_q   <= deb_d;
                stab_q  <= stab_d;
                cnt_q   <= cnt_d;
            end
        end

        // Any cycle where the synced input agrees with the accepted level restarts the count.
        always_comb begin
            deb_d  = deb_q;
            stab_d = '0;
            if (sync2_q != deb_q) begin
                if (stab_q == DebLast) begin
                    deb_d = sync2_q;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            if (clr_cnt) begin
                cnt_d = '0;
            end else if (deb_d && !deb_q && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= StIdle;
                hold_q  <= '0;
`ifdef TRAFFIC_STARVE_GUARD_EN
                fc_q    <= '0;
`endif
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
`ifdef TRAFFIC_STARVE_GUARD_EN
                fc_q    <= fc_d;
`endif
            end
        end

        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
`ifdef TRAFFIC_STARVE_GUARD_EN
            fc_d    = fc_q;
`endif
            unique case (state_q)
                StIdle: begin
                    if (deb_q) state_d = StPresent;
                end
                StPresent: begin
                    if (!deb_q) begin
                        state_d = StExtend;
                        hold_d  = HoldLast;
                    end
                end
                StExtend: begin
                    if (deb_q) begin
                        state_d = StPresent;
                    end else if (hold_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
`ifdef TRAFFIC_STARVE_GUARD_EN
                StForce: begin
                    if (fc_q == '0) begin
                        state_d = deb_q ? StPresent : StIdle;
                    end else begin
                        fc_d = fc_q - 1'b1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
`ifdef TRAFFIC_STARVE_GUARD_EN
            if (force_req[i]) begin
                state_d = StForce;
                fc_d    = ForceLast;
            end
`endif
        end

        always_comb begin
            lane_t = (state_q == StPresent) || (state_q == StExtend);
`ifdef TRAFFIC_STARVE_GUARD_EN
            lane_forced = (state_q == StForce);
`endif
        end

        assign t[i]   = lane_t;
        assign cnt[i] = cnt_q;
`ifdef TRAFFIC_STARVE_GUARD_EN
        assign forced[i] = lane_forced;
`endif
    end

    assign ta    = t[0];
    assign tb    = t[1];
    assign cnt_a = cnt[0];
    assign cnt_b = cnt[1];
`ifdef TRAFFIC_STARVE_GUARD_EN
    assign forced_a = forced[0];
    assign forced_b = forced[1];
`else
    assign forced_a = 1'b0;
    assign forced_b = 1'b0;
`endif

endmodule
